// File: rtl/piso_frame_tx_pkg.sv
// Shared definitions for the serial bit-stream link.
// The transmitter and the receive-side capture stages both use these.
package piso_frame_tx_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_STOP  = S_STOP
  } state_e;

  // Counter width able to hold 0..n-1; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_frame_tx_if.sv
// Load handshake and serial line bundle of the framed transmitter.
interface piso_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             Q;
  logic             busy;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, Q, busy, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, Q, busy, done
  );
endinterface

// File: rtl/piso_frame_tx_bit_period_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick marks the terminal count.
// Also used by the receive end of the link.
module bit_period_counter
  import piso_frame_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clock,
  input  logic Rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (clear || tick) cnt_nxt = '0;
  end

  // tick is registered by looking ahead at the next count
  always_ff @(posedge clock) begin
    if (!Rst) begin
      cnt  <= '0;
      tick <= (CLKS_PER_BIT == 1);
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CW'(CLKS_PER_BIT - 1));
    end
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits,
// stop bit, each held CLKS_PER_BIT clocks.
module piso_frame_tx
  import piso_frame_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          IDLE_LEVEL   = 1'b1
) (
  input  logic            clock,
  input  logic            Rst,
  piso_frame_tx_if.slave  bus
);

  localparam int unsigned BW = cnt_width(WIDTH);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_cnt_nxt;
  logic             q_nxt;
  logic             done_nxt;
  logic             accept;
  logic             clear;
  logic             tick;

  assign accept = bus.load_valid & bus.load_ready;
  assign clear  = (state == ST_IDLE);

  bit_period_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period_counter (
    .clock(clock),
    .Rst  (Rst),
    .clear(clear),
    .tick (tick)
  );

  // Next state, shift register, bit counter and registered-output values
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    q_nxt       = IDLE_LEVEL;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt   = ST_START;
          shreg_nxt   = bus.din;
          bit_cnt_nxt = '0;
        end
      end
      ST_START: begin
        if (tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == BW'(WIDTH - 1)) begin
            state_nxt   = ST_STOP;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
            shreg_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Line level follows the state being entered so Q stays registered
    case (state_nxt)
      ST_START: q_nxt = ~IDLE_LEVEL;
      ST_DATA:  q_nxt = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
      default:  q_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Rst) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      bus.Q          <= IDLE_LEVEL;
      bus.load_ready <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      bit_cnt        <= bit_cnt_nxt;
      bus.Q          <= q_nxt;
      bus.load_ready <= (state_nxt == ST_IDLE);
      bus.busy       <= (state_nxt != ST_IDLE);
      bus.done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: three configurations checked against
// hand-computed line waveforms.
module tb_piso_frame_tx;

  logic clock;
  logic Rst;
  int   n_chk;
  int   n_bad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  piso_frame_tx_if #(.WIDTH(8)) if_m ();
  piso_frame_tx_if #(.WIDTH(8)) if_l ();
  piso_frame_tx_if #(.WIDTH(1)) if_1 ();

  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut_m (
    .clock(clock), .Rst(Rst), .bus(if_m)
  );
  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_l (
    .clock(clock), .Rst(Rst), .bus(if_l)
  );
  piso_frame_tx #(.WIDTH(1), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut_1 (
    .clock(clock), .Rst(Rst), .bus(if_1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // {Q, busy, done, load_ready} of the selected DUT
  function automatic logic [3:0] obs(input int which);
    case (which)
      0:       return {if_m.Q, if_m.busy, if_m.done, if_m.load_ready};
      1:       return {if_l.Q, if_l.busy, if_l.done, if_l.load_ready};
      default: return {if_1.Q, if_1.busy, if_1.done, if_1.load_ready};
    endcase
  endfunction

  task automatic drive(input int which, input logic [7:0] d, input logic v);
    case (which)
      0:       begin if_m.din = d;      if_m.load_valid = v; end
      1:       begin if_l.din = d;      if_l.load_valid = v; end
      default: begin if_1.din = d[0:0]; if_1.load_valid = v; end
    endcase
  endtask

  // Accept word at cycle 0; exp_q[n-c] is the line level expected in cycle c
  task automatic run_frame(input string tag, input int which, input logic [7:0] word,
                           input logic [19:0] exp_q, input int n, input bit wiggle);
    logic [3:0] o;
    drive(which, word, 1'b1);
    for (int c = 1; c <= n; c++) begin
      cyc();
      if (wiggle && c <= n - 2) drive(which, 8'(c * 37 + 5), c[0]);
      else                      drive(which, word, 1'b0);
      o = obs(which);
      check_eq($sformatf("%s_q_c%0d", tag, c), 32'(o[3]), 32'(exp_q[n - c]));
      check_eq($sformatf("%s_busy_c%0d", tag, c), 32'(o[2]), 32'd1);
      check_eq($sformatf("%s_done_c%0d", tag, c), 32'(o[1]), 32'd0);
    end
    cyc();
    o = obs(which);
    check_eq($sformatf("%s_done_end", tag), 32'(o[1]), 32'd1);
    check_eq($sformatf("%s_ready_end", tag), 32'(o[0]), 32'd1);
    check_eq($sformatf("%s_busy_end", tag), 32'(o[2]), 32'd0);
    check_eq($sformatf("%s_q_end", tag), 32'(o[3]), 32'd1);
    cyc();
    o = obs(which);
    check_eq($sformatf("%s_done_after", tag), 32'(o[1]), 32'd0);
    check_eq($sformatf("%s_busy_after", tag), 32'(o[2]), 32'd0);
    check_eq($sformatf("%s_q_after", tag), 32'(o[3]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] o;
    int         dn;
    int         low;
    logic       exp_bit;

    n_chk = 0;
    n_bad = 0;
    Rst   = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);

    // Reset held over three edges, then idle outputs on every DUT
    repeat (3) cyc();
    Rst = 1'b1;
    for (int w = 0; w < 3; w++) begin
      o = obs(w);
      check_eq($sformatf("reset_idle_dut%0d", w), 32'(o), 32'b1001);
    end
    cyc();

    run_frame("t1_msb_a5", 0, 8'hA5, 20'b00110011000011001111, 20, 1'b0);
    run_frame("t2_lsb_01", 1, 8'h01, 20'b00110000000000000011, 20, 1'b0);
    run_frame("t5_wiggle", 0, 8'h96, 20'b00110000110011110011, 20, 1'b1);
    run_frame("t6_w1",     2, 8'h01, 20'b00000000000000000011, 3,  1'b0);

    // Back-to-back: FF then 00 with load_valid held high
    dn = 0;
    drive(0, 8'hFF, 1'b1);
    for (int c = 1; c <= 44; c++) begin
      cyc();
      if (c == 1)  drive(0, 8'h00, 1'b1);
      if (c == 22) drive(0, 8'h00, 1'b0);
      o = obs(0);
      exp_bit = (c <= 2) ? 1'b0 : (c <= 21) ? 1'b1 : (c <= 39) ? 1'b0 : 1'b1;
      check_eq($sformatf("t4_q_c%0d", c), 32'(o[3]), 32'(exp_bit));
      check_eq($sformatf("t4_done_c%0d", c), 32'(o[1]), 32'((c == 21) || (c == 42)));
      if (o[1]) dn++;
    end
    check_eq("t4_done_count", 32'(dn), 32'd2);

    // Reset at cycle 9 of a frame aborts it without a done pulse
    drive(0, 8'hA5, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      drive(0, 8'hA5, 1'b0);
    end
    o = obs(0);
    check_eq("t3_mid_q_c9", 32'(o[3]), 32'd0);
    check_eq("t3_mid_busy_c9", 32'(o[2]), 32'd1);
    Rst = 1'b0;
    cyc();
    o = obs(0);
    check_eq("t3_abort_idle", 32'(o), 32'b1001);
    Rst = 1'b1;
    dn  = 0;
    low = 0;
    for (int c = 0; c < 25; c++) begin
      cyc();
      o = obs(0);
      if (o[1]) dn++;
      if (!o[3]) low++;
    end
    check_eq("t3_no_done", 32'(dn), 32'd0);
    check_eq("t3_line_idle", 32'(low), 32'd0);
    run_frame("t3_recover", 0, 8'hA5, 20'b00110011000011001111, 20, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
Parallel-in/serial-out framed transmitter built from a D-flip-flop shift chain. It is the transmit end of the serial bit-stream link; the team's D-flip-flop/shift-register capture stages form the receive end. It accepts a WIDTH-bit word over a valid/ready handshake and drives it on a single line as start bit, data bits, stop bit, each held for CLKS_PER_BIT clocks.

Parameters:
WIDTH, 8, data bits per frame (>=1)
CLKS_PER_BIT, 1, clock cycles each line bit is held (>=1)
MSB_FIRST, 1, 1 = send din[WIDTH-1] first, 0 = send din[0] first
IDLE_LEVEL, 1, line level when idle and for the stop bit; the start bit is ~IDLE_LEVEL

Ports:
clock  input  1  single clock; all state changes on posedge
Rst  input  1  reset, synchronous, active-low (0 at posedge = reset)
din  input  WIDTH  word to send; sampled only on an accepted load
load_valid  input  1  din is valid
load_ready  output  1  transmitter idle, can accept a word
Q  output  1  serial line out, registered
busy  output  1  frame in progress (START/DATA/STOP)
done  output  1  one-cycle pulse after the last stop-bit cycle

Behaviour:
- Reset, any state, mid-frame included: state=IDLE, Q=IDLE_LEVEL, load_ready=1, busy=0, done=0. Shift register and counters are cleared.
- Reset aborts a frame immediately. No done pulse is generated, and the partial frame is not resumed.
- FSM states are IDLE, START, DATA, STOP. All outputs are registered.
- IDLE: Q=IDLE_LEVEL, load_ready=1. A handshake at posedge (load_valid & load_ready) captures din into the shift register and moves to START. load_ready drops and busy rises in the next cycle.
- START: Q=~IDLE_LEVEL for CLKS_PER_BIT cycles, then DATA.
- DATA: Q = current bit for CLKS_PER_BIT cycles each, WIDTH bits in total.
  - Order: MSB_FIRST=1 shifts left and outputs bit WIDTH-1; MSB_FIRST=0 shifts right and outputs bit 0.
  - Bit counter runs 0..WIDTH-1. After the last bit the FSM goes to STOP.
- STOP: Q=IDLE_LEVEL for CLKS_PER_BIT cycles, then IDLE.
- In the first IDLE cycle after STOP: done=1 for exactly one cycle, load_ready=1, busy=0.
- Latency: accept edge at cycle 0 → start bit on Q in cycles 1..CLKS_PER_BIT. Last stop cycle is (WIDTH+2)*CLKS_PER_BIT. done and load_ready are high at cycle (WIDTH+2)*CLKS_PER_BIT+1.
- Back-to-back: load_valid held high means the next word is accepted on the done cycle. The line therefore stays at stop level for CLKS_PER_BIT+1 cycles between frames.
- load_valid and din changes while busy are ignored. There is no queueing, and the loaded word is stable for the whole frame.
- Bit-period counter: width $clog2(CLKS_PER_BIT) (minimum 1). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. With CLKS_PER_BIT=1 it is always at terminal count.
- Bit counter width: $clog2(WIDTH) (minimum 1). It must not overflow for WIDTH equal to a power of two.
- Encoding illegal states: any unreachable state returns to IDLE at the next edge, with Q=IDLE_LEVEL.

Decomposition:
- Shared header file (`included): FSM state encodings as localparams S_IDLE=2'd0, S_START=2'd1, S_DATA=2'd2, S_STOP=2'd3. The receiver uses the same constants.
- One sub-module: bit_period_counter, with parameter CLKS_PER_BIT, inputs clock/Rst/clear, and output tick asserted on the terminal count. It is instantiated once and is reused by the receive end.

Test Plan:
1. WIDTH=8, CLKS_PER_BIT=2, MSB_FIRST=1, din=8'hA5 accepted at cycle 0 → expected response:
   - Q: cycles 1-2 = 0; cycles 3-18 = 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1; cycles 19-20 = 1.
   - done=1 only in cycle 21; load_ready=1 in cycle 21.
2. Same config, MSB_FIRST=0, din=8'h01 → expected response:
   - Data bits: first data bit is 1 (cycles 3-4), followed by seven 0 bits.
   - busy=1 for cycles 1-20.
3. Hold Rst=0 over 3 edges, release → Q=1, load_ready=1, busy=0, done=0. Then assert Rst=0 at cycle 9 of a frame → next cycle Q=1, IDLE, no done pulse.
4. Back-to-back: load_valid held high with din=8'hFF then 8'h00 → second start bit begins cycle 22. The line stays 1 over cycles 19-21, and exactly two done pulses occur.
5. During a frame, toggle din and load_valid every cycle → Q matches the originally loaded word bit-for-bit, and no extra accepts occur.
6. CLKS_PER_BIT=1, WIDTH=1, din=1 → Q = 0,1,1 in cycles 1-3, done in cycle 4.
